// File: rtl/sort_dispatch_ctrl.sv
// sort_dispatch_ctrl: edge-detects the item sensors into a FIFO of sort jobs and
// runs exactly one sorting motor at a time for RUN_CYCLES, followed by a GAP_CYCLES dwell.
module sort_dispatch_ctrl #(
  parameter int RUN_CYCLES = 8,
  parameter int GAP_CYCLES = 2,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   detect_bowl,
  input  logic                   detect_chopstick,
  input  logic                   detect_plate,
  output logic                   motor_1,
  output logic                   motor_2,
  output logic                   motor_3,
  output logic                   busy,
  output logic                   queue_full,
  output logic [$clog2(DEPTH):0] item_count,
  output logic                   overflow,
  output logic                   conflict
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(RUN_CYCLES + GAP_CYCLES + 1) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] RUN_LOAD = TW'(RUN_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : {TW{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      motor_q, motor_d;
  logic            busy_q, busy_d;
  logic [2:0]      sense_q, sense_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            overflow_q, overflow_d;
  logic            conflict_q, conflict_d;

  logic [2:0]      rise;
  logic            multi_rise, single_rise, push, pop;
  logic [1:0]      new_code;

  // Job code 1/2/3 selects motor_1/motor_2/motor_3; anything else selects none.
  function automatic logic [2:0] decode_job(input logic [1:0] code);
    logic [2:0] onehot;
    case (code)
      2'd1:    onehot = 3'b001;
      2'd2:    onehot = 3'b010;
      2'd3:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
    return onehot;
  endfunction

  // Dispatch sequencer: IDLE pops the head job, RUN holds one motor, GAP dwells with motors off.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    motor_d = motor_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (count_q != {CW{1'b0}})) begin
          pop     = 1'b1;
          state_d = RUN;
          timer_d = RUN_LOAD;
          motor_d = decode_job(mem_q[rd_ptr_q]);
          busy_d  = 1'b1;
        end else begin
          motor_d = 3'b000;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        if (timer_q == {TW{1'b0}}) begin
          motor_d = 3'b000;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            timer_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        motor_d = 3'b000;
        if (timer_q == {TW{1'b0}}) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        motor_d = 3'b000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sensor edge detection and job FIFO; simultaneous edges are all discarded.
  always_comb begin
    sense_d     = {detect_plate, detect_chopstick, detect_bowl};
    rise        = sense_d & ~sense_q;
    multi_rise  = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    single_rise = (rise != 3'b000) && !multi_rise;
    if (rise[0]) begin
      new_code = 2'd1;
    end else if (rise[1]) begin
      new_code = 2'd2;
    end else begin
      new_code = 2'd3;
    end
    // When full, a same-cycle pop frees the slot the push overwrites.
    push       = single_rise && ((count_q != FULL_CNT) || pop);
    overflow_d = overflow_q | (single_rise & (count_q == FULL_CNT) & ~pop);
    conflict_d = conflict_q | multi_rise;
    mem_d      = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_code;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == FULL_CNT);
  end

  // State, FIFO and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= {TW{1'b0}};
      motor_q    <= 3'b000;
      busy_q     <= 1'b0;
      sense_q    <= 3'b000;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      conflict_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      motor_q    <= motor_d;
      busy_q     <= busy_d;
      sense_q    <= sense_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      conflict_q <= conflict_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign motor_1    = motor_q[0];
  assign motor_2    = motor_q[1];
  assign motor_3    = motor_q[2];
  assign busy       = busy_q;
  assign queue_full = full_q;
  assign item_count = count_q;
  assign overflow   = overflow_q;
  assign conflict   = conflict_q;
endmodule

// File: tb/tb_sort_dispatch_ctrl.sv
// Bench for sort_dispatch_ctrl: a queue-and-countdown model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sort_dispatch_ctrl;
  localparam int RUN   = 8;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic detect_bowl = 1'b0, detect_chopstick = 1'b0, detect_plate = 1'b0;
  logic motor_1, motor_2, motor_3, busy, queue_full, overflow, conflict;
  logic [2:0] item_count;

  sort_dispatch_ctrl #(.RUN_CYCLES(RUN), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .detect_bowl(detect_bowl), .detect_chopstick(detect_chopstick), .detect_plate(detect_plate),
    .motor_1(motor_1), .motor_2(motor_2), .motor_3(motor_3),
    .busy(busy), .queue_full(queue_full), .item_count(item_count),
    .overflow(overflow), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of waiting job codes, remaining motor-on cycles, remaining gap cycles.
  int mq[$];
  int m_run = 0, m_gap = 0, m_code = 0, m_n = 0;
  logic m_ovf = 1'b0, m_conf = 1'b0;
  logic [2:0] m_prev = 3'b000, m_cur, m_e;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_run = 0; m_gap = 0; m_code = 0;
      m_ovf = 1'b0; m_conf = 1'b0; m_prev = 3'b000;
    end else begin
      m_cur  = {detect_plate, detect_chopstick, detect_bowl};
      m_e    = m_cur & ~m_prev;
      m_prev = m_cur;
      if (m_run > 0) begin
        m_run--;
        if (m_run == 0) m_gap = GAP;
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (start && mq.size() > 0) begin
        m_code = mq.pop_front();
        m_run  = RUN;
      end
      m_n = $countones(m_e);
      if (m_n > 1) m_conf = 1'b1;
      else if (m_n == 1) begin
        if (mq.size() < DEPTH) mq.push_back(m_e[0] ? 1 : (m_e[1] ? 2 : 3));
        else m_ovf = 1'b1;
      end
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scenario statistics gathered from the DUT outputs.
  int rises[3], on_cyc[3], rise_c[3], fall_c[3];
  int rise_seq[$];
  int peak, first_cnt_c, busy_fall_c;
  logic [2:0] mprev = 3'b000, mnow;
  logic busy_prev = 1'b0;

  task automatic clear_stats();
    for (int k = 0; k < 3; k++) begin
      rises[k] = 0; on_cyc[k] = 0; rise_c[k] = -1; fall_c[k] = -1;
    end
    rise_seq.delete();
    peak = 0; first_cnt_c = -1; busy_fall_c = -1;
  endtask

  // Per-cycle compare against the model, then statistics update.
  initial forever begin
    @(negedge clk);
    chk("cmp motor_1", motor_1, (m_run > 0 && m_code == 1));
    chk("cmp motor_2", motor_2, (m_run > 0 && m_code == 2));
    chk("cmp motor_3", motor_3, (m_run > 0 && m_code == 3));
    chk("cmp busy", busy, (m_run > 0 || m_gap > 0));
    chk("cmp item_count", item_count, mq.size());
    chk("cmp queue_full", queue_full, (mq.size() == DEPTH));
    chk("cmp overflow", overflow, m_ovf);
    chk("cmp conflict", conflict, m_conf);
    mnow = {motor_3, motor_2, motor_1};
    for (int k = 0; k < 3; k++) begin
      if (mnow[k] && !mprev[k]) begin
        rises[k]++; rise_c[k] = cyc; rise_seq.push_back(k + 1);
      end
      if (!mnow[k] && mprev[k]) fall_c[k] = cyc;
      if (mnow[k]) on_cyc[k]++;
    end
    mprev = mnow;
    if (int'(item_count) > peak) peak = int'(item_count);
    if (item_count != 3'd0 && first_cnt_c < 0) first_cnt_c = cyc;
    if (busy_prev && !busy) busy_fall_c = cyc;
    busy_prev = busy;
  end

  task automatic set_det(input logic [2:0] v);
    @(negedge clk);
    {detect_plate, detect_chopstick, detect_bowl} = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {detect_plate, detect_chopstick, detect_bowl} = 3'b000;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();
  endtask

  int exp4[4] = '{1, 2, 3, 1};

  initial begin
    clear_stats();
    #2;
    chk("reset item_count", item_count, 0);
    chk("reset motors", {motor_3, motor_2, motor_1}, 0);
    chk("reset busy", busy, 0);
    chk("reset flags", {queue_full, overflow, conflict}, 0);
    idle(2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();

    // Single bowl, 2-cycle pulse.
    start = 1'b1;
    set_det(3'b001);
    set_det(3'b001);
    set_det(3'b000);
    idle(20);
    chk("single motor_1 on", on_cyc[0], 8);
    chk("single motor_1 rises", rises[0], 1);
    chk("single others off", on_cyc[1] + on_cyc[2], 0);
    chk("single latency", rise_c[0] - first_cnt_c, 1);
    chk("single busy fall", busy_fall_c - fall_c[0], 2);

    // Order: bowl, chopstick, plate one cycle apart.
    do_reset();
    set_det(3'b001);
    set_det(3'b010);
    set_det(3'b100);
    set_det(3'b000);
    idle(45);
    chk("order count", rise_seq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("order seq %0d", i), (i < rise_seq.size()) ? rise_seq[i] : 0, i + 1);
      chk($sformatf("order on %0d", i), on_cyc[i], 8);
    end
    chk("order gap 1-2", rise_c[1] - fall_c[0], 3);
    chk("order gap 2-3", rise_c[2] - fall_c[1], 3);
    chk("order peak", peak, 2);

    // Conflict: bowl and plate rise together.
    do_reset();
    set_det(3'b101);
    set_det(3'b000);
    idle(20);
    chk("conflict no motor", rise_seq.size(), 0);
    chk("conflict peak", peak, 0);
    chk("conflict flag", conflict, 1);
    chk("conflict no ovf", overflow, 0);
    do_reset();
    chk("conflict cleared", conflict, 0);

    // Overflow with start low, then release start.
    start = 1'b0;
    set_det(3'b001); set_det(3'b000);
    set_det(3'b010); set_det(3'b000);
    set_det(3'b100); set_det(3'b000);
    set_det(3'b001); set_det(3'b000);
    set_det(3'b010); set_det(3'b000);
    @(posedge clk);
    #2;
    chk("ovf item_count", item_count, 4);
    chk("ovf queue_full", queue_full, 1);
    chk("ovf flag", overflow, 1);
    chk("ovf no motor", rise_seq.size(), 0);
    @(negedge clk);
    start = 1'b1;
    idle(60);
    chk("ovf jobs run", rise_seq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf seq %0d", i), (i < rise_seq.size()) ? rise_seq[i] : 0, exp4[i]);
    chk("ovf drained", item_count, 0);
    chk("ovf sticky", overflow, 1);

    // Held level produces one job.
    do_reset();
    set_det(3'b100);
    idle(29);
    set_det(3'b000);
    idle(15);
    chk("held rises", rises[2], 1);
    chk("held total", rise_seq.size(), 1);
    chk("held on", on_cyc[2], 8);

    // Reset in cycle 4 of a motor_2 job with two jobs queued.
    do_reset();
    set_det(3'b010);
    set_det(3'b001);
    set_det(3'b100);
    set_det(3'b000);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid motor_2", motor_2, 1);
    chk("mid queued", item_count, 2);
    reset = 1'b1;
    #1;
    chk("rst motors", {motor_3, motor_2, motor_1}, 0);
    chk("rst busy", busy, 0);
    chk("rst item_count", item_count, 0);
    chk("rst queue_full", queue_full, 0);
    idle(2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();
    idle(30);
    chk("rst no motor after", rise_seq.size(), 0);
    chk("rst empty after", peak, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
